ub_result_streamer: RTL and testbench

// Readback engine for the unified buffer (UB). On a start command it reads a contiguous run of 256-bit UB rows.
// It serializes each row into bytes on a valid/ready stream that feeds the UART transmitter, so results go back to the host.
// It drives the same ub_rd_en / ub_rd_addr / ub_rd_data read port that the board test interface muxes toward the TPU core.

---
 rtl/ub_result_streamer.sv | 189 ++++++++++++++++++
 tb/tb_ub_result_streamer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ub_result_streamer.sv
// ub_result_streamer: reads a contiguous run of UB rows and streams them out LSB byte first on a valid/ready port.
// Optional trailing 8-bit checksum byte when UB_STREAM_CHECKSUM_EN is defined.
module ub_result_streamer #(
    parameter int unsigned ROW_W  = 256,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 9,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  row_count,
    output logic              busy,
    output logic              done,
    output logic              ub_rd_en,
    output logic [ADDR_W-1:0] ub_rd_addr,
    input  logic [ROW_W-1:0]  ub_rd_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready
);

    localparam int unsigned NBYTES = ROW_W / 8;
    localparam int unsigned BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

`ifdef UB_STREAM_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SEND, S_CSUM, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SEND, S_DONE} state_t;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    row_idx_q, row_idx_d;
    logic [BI_W-1:0]     byte_idx_q, byte_idx_d;
    logic [LAT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [ROW_W-1:0]    row_q, row_d;
`ifdef UB_STREAM_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;
`endif
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                accept;

    assign busy       = busy_q;
    assign done       = done_q;
    assign ub_rd_en   = rd_en_q;
    assign ub_rd_addr = rd_addr_q;
    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;

    // Next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        row_idx_d  = row_idx_q;
        byte_idx_d = byte_idx_q;
        wait_cnt_d = wait_cnt_q;
        row_d      = row_q;
`ifdef UB_STREAM_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        accept     = tx_valid_q && tx_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d     = base_addr;
                    count_d    = row_count;
                    row_idx_d  = '0;
                    byte_idx_d = '0;
`ifdef UB_STREAM_CHECKSUM_EN
                    sum_d      = 8'h00;
                    state_d    = (row_count == '0) ? S_CSUM : S_REQ;
`else
                    state_d    = (row_count == '0) ? S_DONE : S_REQ;
`endif
                end
            end
            S_REQ: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == LAT_W'(RD_LAT - 1)) begin
                    row_d   = ub_rd_data;
                    state_d = S_SEND;
                end else begin
                    wait_cnt_d = LAT_W'(wait_cnt_q + 1'b1);
                end
            end
            S_SEND: begin
                if (accept) begin
`ifdef UB_STREAM_CHECKSUM_EN
                    sum_d = sum_q + tx_data_q;
`endif
                    if (byte_idx_q == BI_W'(NBYTES - 1)) begin
                        byte_idx_d = '0;
                        row_idx_d  = CNT_W'(row_idx_q + 1'b1);
                        if (row_idx_d == count_q) begin
`ifdef UB_STREAM_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            state_d = S_REQ;
                        end
                    end else begin
                        byte_idx_d = BI_W'(byte_idx_q + 1'b1);
                    end
                end
            end
`ifdef UB_STREAM_CHECKSUM_EN
            S_CSUM: begin
                if (accept) state_d = S_DONE;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        rd_en_d    = (state_d == S_REQ);
        rd_addr_d  = rd_en_d ? (base_d + ADDR_W'(row_idx_d)) : rd_addr_q;
        tx_valid_d = (state_d == S_SEND);
        tx_data_d  = 8'h00;
        if (state_d == S_SEND) tx_data_d = row_d[{byte_idx_d, 3'b000} +: 8];
`ifdef UB_STREAM_CHECKSUM_EN
        if (state_d == S_CSUM) begin
            tx_valid_d = 1'b1;
            tx_data_d  = sum_d;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            row_idx_q  <= '0;
            byte_idx_q <= '0;
            wait_cnt_q <= '0;
            row_q      <= '0;
`ifdef UB_STREAM_CHECKSUM_EN
            sum_q      <= 8'h00;
`endif
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            row_idx_q  <= row_idx_d;
            byte_idx_q <= byte_idx_d;
            wait_cnt_q <= wait_cnt_d;
            row_q      <= row_d;
`ifdef UB_STREAM_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_ub_result_streamer.sv
// Testbench for ub_result_streamer: table-driven transfers plus randomized transfers against a queue-based model.
// Follows UB_STREAM_CHECKSUM_EN the same way the design does.
module tb_ub_result_streamer;

`ifdef UB_STREAM_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [7:0]   base_addr;
    logic [8:0]   row_count;
    logic         busy;
    logic         done;
    logic         ub_rd_en;
    logic [7:0]   ub_rd_addr;
    logic [255:0] ub_rd_data;
    logic         tx_valid;
    logic [7:0]   tx_data;
    logic         tx_ready;

    ub_result_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .row_count  (row_count),
        .busy       (busy),
        .done       (done),
        .ub_rd_en   (ub_rd_en),
        .ub_rd_addr (ub_rd_addr),
        .ub_rd_data (ub_rd_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ecnt = 0;
    int t0 = 0;
    int rel;
    int first_tx;
    int done_cnt;
    int done_rel;
    int rdy_mode = 0;
    int rdy_i = 0;
    bit mon_on = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic [7:0] addr_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [255:0] ub_mem [256];

    typedef struct {
        logic [7:0] base;
        int         count;
        int         mode;          // 0: ready high, 1: 1,0,0 pattern, 2: random
        int         spur;          // cycle of an extra start pulse, 0 = none
        int         exp_first_tx;  // -1 never, -2 unchecked
        int         exp_done;      // -2 unchecked
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) ecnt <= ecnt + 1;

    // UB model with one cycle read latency; returns noise when not reading
    always @(posedge clk) begin
        if (ub_rd_en) ub_rd_data <= ub_mem[ub_rd_addr];
        else ub_rd_data <= {8{$urandom}};
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: tx_ready = 1'b1;
            1: begin
                tx_ready = (rdy_i % 3 == 0);
                rdy_i++;
            end
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Stream monitor: records reads, accepted bytes and done pulses
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            rel = ecnt - t0;
            if (ub_rd_en) addr_q.push_back(ub_rd_addr);
            if (tx_valid) begin
                if (first_tx < 0) first_tx = rel;
                if (prev_stall) check("stall_hold", 64'(tx_data), 64'(prev_data));
                if (tx_ready) got_q.push_back(tx_data);
                prev_stall = !tx_ready;
                prev_data  = tx_data;
            end else begin
                if (prev_stall) check("valid_drop", 64'(tx_valid), 64'd1);
                prev_stall = 1'b0;
            end
            if (done) begin
                done_cnt++;
                done_rel = rel;
                check("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    function automatic void build_expected(input logic [7:0] base, input int count);
        logic [7:0] sum;
        logic [255:0] row;
        exp_q.delete();
        sum = 8'h00;
        for (int r = 0; r < count; r++) begin
            row = ub_mem[(int'(base) + r) % 256];
            for (int b = 0; b < 32; b++) begin
                exp_q.push_back(row[8*b +: 8]);
                sum = sum + row[8*b +: 8];
            end
        end
        if (CS == 1) exp_q.push_back(sum);
    endfunction

    task automatic run_xfer(input string name, input vec_t v);
        int limit;
        int k;
        build_expected(v.base, v.count);
        addr_q.delete();
        got_q.delete();
        first_tx   = -1;
        done_cnt   = 0;
        done_rel   = -1;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rdy_mode  = v.mode;
        rdy_i     = 0;
        start     = 1'b1;
        base_addr = v.base;
        row_count = 9'(v.count);
        t0        = ecnt;
        mon_on    = 1'b1;
        limit = v.count * 34 * 8 + 40;
        k = 0;
        while (done_cnt == 0 && k < limit) begin
            @(posedge clk);
            #1;
            k++;
            start = (v.spur > 0) && ((ecnt - t0) == v.spur);
            if (start) begin
                base_addr = 8'h55;
                row_count = 9'd3;
            end
        end
        start = 1'b0;
        check({name, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        mon_on = 1'b0;
        check({name, "_done_count"}, 64'(done_cnt), 64'd1);
        if (v.exp_done != -2) check({name, "_done_cycle"}, 64'(done_rel), 64'(v.exp_done));
        if (v.exp_first_tx != -2) check({name, "_first_tx"}, 64'(first_tx), 64'(v.exp_first_tx));
        check({name, "_rd_pulses"}, 64'(addr_q.size()), 64'(v.count));
        for (int i = 0; i < addr_q.size() && i < v.count; i++)
            check($sformatf("%s_addr%0d", name, i), 64'(addr_q[i]), 64'((int'(v.base) + i) % 256));
        check({name, "_nbytes"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        vec_t v;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = 8'h00;
        row_count = 9'd0;
        tx_ready  = 1'b0;
        ub_rd_data = '0;
        for (int a = 0; a < 256; a++) ub_mem[a] = {8{$urandom}};
        for (int b = 0; b < 32; b++) ub_mem[16][8*b +: 8] = 8'(b);

        tbl[0] = '{8'h10, 1,   0, 0,  3,        35 + CS};
        tbl[1] = '{8'h10, 1,   1, 0,  3,        -2};
        tbl[2] = '{8'hFF, 2,   0, 0,  3,        69 + CS};
        tbl[3] = '{8'h42, 0,   0, 0,  2*CS - 1, 1 + CS};
        tbl[4] = '{8'h10, 1,   0, 10, 3,        35 + CS};
        tbl[5] = '{8'h80, 3,   2, 0,  3,        -2};
        tbl[6] = '{8'hC0, 256, 0, 0,  3,        34*256 + 1 + CS};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",     64'(busy),       64'd0);
        check("rst_done",     64'(done),       64'd0);
        check("rst_rd_en",    64'(ub_rd_en),   64'd0);
        check("rst_rd_addr",  64'(ub_rd_addr), 64'd0);
        check("rst_tx_valid", 64'(tx_valid),   64'd0);
        check("rst_tx_data",  64'(tx_data),    64'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_xfer($sformatf("vec%0d", i), tbl[i]);
`ifdef UB_STREAM_CHECKSUM_EN
            if (i == 0 && got_q.size() == 33) check("csum_f0", 64'(got_q[32]), 64'hF0);
`endif
        end

        // Reset in the middle of a row: outputs drop at once and no done follows
        @(posedge clk);
        #1;
        rdy_mode  = 0;
        done_cnt  = 0;
        prev_stall = 1'b0;
        first_tx  = -1;
        start     = 1'b1;
        base_addr = 8'h10;
        row_count = 9'd1;
        t0        = ecnt;
        mon_on    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre_rst_tx_valid", 64'(tx_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
        check("mid_rst_busy",     64'(busy),     64'd0);
        check("mid_rst_done",     64'(done),     64'd0);
        repeat (40) @(posedge clk);
        #1;
        mon_on = 1'b0;
        check("mid_rst_no_done", 64'(done_cnt), 64'd0);
        run_xfer("after_rst", tbl[0]);

        for (int n = 0; n < 12; n++) begin
            v.base  = 8'($urandom);
            v.count = $urandom_range(0, 4);
            v.mode  = $urandom_range(0, 2);
            v.spur  = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 40) : 0;
            v.exp_first_tx = -2;
            v.exp_done     = -2;
            run_xfer($sformatf("rnd%0d", n), v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
